// File: rtl/cpu_qsys_cpu_ocimem_pkg.sv
// Shared types and constants for the OCI debug RAM arbiter.
//   - FSM state, requester and JTAG op enums
//   - bit positions of the fields carried on jdo
//   - default RAM geometry
package cpu_qsys_cpu_ocimem_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 32;

  // jdo layout: [35] read-on-load, [34:3] write data, [33:26] address
  localparam int unsigned JDO_W          = 38;
  localparam int unsigned JDO_ADDR_LSB   = 26;
  localparam int unsigned JDO_WDATA_LSB  = 3;
  localparam int unsigned JDO_RD_ON_LOAD = 35;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StCapture
  } state_e;

  typedef enum logic {
    ReqCpu,
    ReqJtag
  } req_e;

  typedef enum logic {
    OpRd,
    OpWr
  } op_e;

endpackage

// File: rtl/cpu_qsys_cpu_ocimem_jtag_cmd.sv
// JTAG command latch for the OCI debug RAM arbiter.
// Decodes the single-cycle take_action strobes into one pending RAM command,
// keeps the auto-incrementing JTAG word address and the sticky overrun flag.
// Ports:
//   clk, reset             - system clock, async active-high reset
//   jdo, take_*            - JTAG decoder strobes and data
//   done                   - pending JTAG access finished this cycle
//   pend_valid/op/wdata    - the pending command
//   jtag_addr              - RAM address for the next JTAG access
//   jtag_overrun           - sticky: a command arrived while one was pending
module cpu_qsys_cpu_ocimem_jtag_cmd
  import cpu_qsys_cpu_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              done,
  output logic              pend_valid,
  output op_e               pend_op,
  output logic [DATA_W-1:0] pend_wdata,
  output logic [ADDR_W-1:0] jtag_addr,
  output logic              jtag_overrun
);

  logic load;
  logic enq;
  logic unused_jdo;

  assign load = take_action_ocimem_a;
  assign enq  = (load & jdo[JDO_RD_ON_LOAD]) | take_action_ocimem_b | take_no_action_ocimem_a;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_ON_LOAD+1], jdo[JDO_WDATA_LSB-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid   <= 1'b0;
      pend_op      <= OpRd;
      pend_wdata   <= '0;
      jtag_addr    <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      // Single-entry latch: a strobe landing while busy is dropped, even if
      // the pending entry completes in the same cycle.
      if (enq && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_op    <= take_action_ocimem_b ? OpWr : OpRd;
        pend_wdata <= jdo[JDO_WDATA_LSB +: DATA_W];
      end else if (done) begin
        pend_valid <= 1'b0;
      end

      // A drop in the same cycle as a clearing load still reports the drop.
      if (enq && pend_valid) begin
        jtag_overrun <= 1'b1;
      end else if (load) begin
        jtag_overrun <= 1'b0;
      end

      // Load beats increment.
      if (load) begin
        jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if (done) begin
        jtag_addr <= jtag_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_qsys_cpu_ocimem_arbiter.sv
// Arbiter sharing the single-port OCI debug RAM (1-cycle read latency)
// between the JTAG debug path and the CPU debug-slave Avalon port.
// Ports:
//   clk, reset                   - system clock, async active-high reset
//   jdo, take_*                  - JTAG decoder strobes and data
//   cpu_*                        - Avalon slave (requests held until accepted)
//   ram_*                        - RAM strobes, address, data, byte enables
//   MonDReg, jtag_rd_done        - last JTAG read data and its update pulse
//   jtag_overrun                 - sticky dropped-JTAG-command flag
// Build option: define CPU_QSYS_OCIMEM_JTAG_PRIO_EN for fixed JTAG priority
// on ties; otherwise ties are resolved round-robin.
module cpu_qsys_cpu_ocimem_arbiter
  import cpu_qsys_cpu_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_writedata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  output logic                cpu_waitrequest,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                jtag_rd_done,
  output logic                jtag_overrun
);

  logic              pend_valid;
  op_e               pend_op;
  logic [DATA_W-1:0] pend_wdata;
  logic [ADDR_W-1:0] jtag_addr;
  logic              jtag_done;

  state_e              state_q;
  req_e                grant_q;
  logic                ram_en_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic [DATA_W/8-1:0] ram_be_q;
  logic                wait_q;
  logic [DATA_W-1:0]   mon_q;
  logic                rd_done_q;

  logic cpu_req;
  logic grant_jtag;

  cpu_qsys_cpu_ocimem_jtag_cmd #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_cmd (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .done                    (jtag_done),
    .pend_valid              (pend_valid),
    .pend_op                 (pend_op),
    .pend_wdata              (pend_wdata),
    .jtag_addr               (jtag_addr),
    .jtag_overrun            (jtag_overrun)
  );

  assign cpu_req = cpu_read | cpu_write;

`ifdef CPU_QSYS_OCIMEM_JTAG_PRIO_EN
  assign grant_jtag = pend_valid;
`else
  req_e last_grant_q;
  // The requester not served last wins a tie.
  assign grant_jtag = pend_valid & (~cpu_req | (last_grant_q == ReqCpu));
`endif

  // JTAG completion: write in ACCESS, read in CAPTURE.
  assign jtag_done = (grant_q == ReqJtag) &&
                     (((state_q == StAccess) && ram_we_q) || (state_q == StCapture));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= ReqCpu;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_be_q     <= '0;
      wait_q       <= 1'b1;
      mon_q        <= '0;
      rd_done_q    <= 1'b0;
`ifndef CPU_QSYS_OCIMEM_JTAG_PRIO_EN
      last_grant_q <= ReqCpu;
`endif
    end else begin
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      wait_q    <= 1'b1;
      rd_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req || pend_valid) begin
            state_q  <= StAccess;
            ram_en_q <= 1'b1;
            if (grant_jtag) begin
              grant_q     <= ReqJtag;
              ram_we_q    <= (pend_op == OpWr);
              ram_addr_q  <= jtag_addr;
              ram_wdata_q <= pend_wdata;
              ram_be_q    <= '1;
            end else begin
              grant_q     <= ReqCpu;
              ram_we_q    <= cpu_write;
              ram_addr_q  <= cpu_address;
              ram_wdata_q <= cpu_writedata;
              ram_be_q    <= cpu_byteenable;
              // A CPU write completes in ACCESS, so release the stall there.
              wait_q      <= ~cpu_write;
            end
`ifndef CPU_QSYS_OCIMEM_JTAG_PRIO_EN
            last_grant_q <= grant_jtag ? ReqJtag : ReqCpu;
`endif
          end
        end
        StAccess: begin
          if (ram_we_q) begin
            state_q <= StIdle;
          end else begin
            state_q <= StCapture;
            if (grant_q == ReqCpu) begin
              wait_q <= 1'b0;
            end
          end
        end
        StCapture: begin
          state_q <= StIdle;
          if (grant_q == ReqJtag) begin
            mon_q     <= ram_rdata;
            rd_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_waitrequest = wait_q;
  assign cpu_readdata    = ram_rdata;
  assign ram_en          = ram_en_q;
  assign ram_we          = ram_we_q;
  assign ram_addr        = ram_addr_q;
  assign ram_wdata       = ram_wdata_q;
  assign ram_be          = ram_be_q;
  assign MonDReg         = mon_q;
  assign jtag_rd_done    = rd_done_q;

endmodule
